// File: rtl/multicycle_ctrl_p_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_p_if
// Bundle between the multi-cycle control FSM and its datapath/IR/memory side.
//   slave  : the controller (reads inst/flags, drives every control output)
//   master : the datapath side (drives inst/flags, consumes control outputs)
// Signals:
//   inst, zero_out, mem_ready                         -> controller
//   pc_write .. alu_src_a, alu_src_b, pc_src, alu_op  <- controller (datapath controls)
//   fault, state_dbg, cycle_cnt, instret_cnt          <- controller (status / perf)
// ---------------------------------------------------------------------------
interface multicycle_ctrl_p_if #(
  parameter int INST_W = 16,
  parameter int CNT_W  = 32
);
  logic [INST_W-1:0] inst;
  logic              zero_out;
  logic              mem_ready;

  logic              pc_write;
  logic              pc_write_cond;
  logic              zero_in;
  logic              iord;
  logic              mem_read;
  logic              mem_write;
  logic              ir_write;
  logic              reg_dst1;
  logic              reg_write1;
  logic              mem_to_reg;
  logic              reg_dst2;
  logic              reg_write2;
  logic              alu_src_a;
  logic [1:0]        alu_src_b;
  logic [1:0]        pc_src;
  logic [2:0]        alu_op;
  logic              fault;
  logic [3:0]        state_dbg;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [CNT_W-1:0]  instret_cnt;

  modport slave (
    input  inst, zero_out, mem_ready,
    output pc_write, pc_write_cond, zero_in, iord, mem_read, mem_write, ir_write,
           reg_dst1, reg_write1, mem_to_reg, reg_dst2, reg_write2, alu_src_a,
           alu_src_b, pc_src, alu_op, fault, state_dbg, cycle_cnt, instret_cnt
  );

  modport master (
    output inst, zero_out, mem_ready,
    input  pc_write, pc_write_cond, zero_in, iord, mem_read, mem_write, ir_write,
           reg_dst1, reg_write1, mem_to_reg, reg_dst2, reg_write2, alu_src_a,
           alu_src_b, pc_src, alu_op, fault, state_dbg, cycle_cnt, instret_cnt
  );
endinterface

// File: rtl/multicycle_ctrl_p.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_p
// Moore-style multi-cycle CPU controller: fetch, decode, then a per-class
// execute/writeback sequence. Memory states (IF, LOAD1, STORE) wait on
// mem_ready and fall into a sticky FAULT state on timeout; an illegal opcode
// (0011) also lands in FAULT. FAULT is left only through rst.
// Ports:
//   clock : rising-edge system clock
//   rst   : asynchronous active-high reset; all control outputs read 0 while high
//   bus   : multicycle_ctrl_p_if.slave (inst/flags in, datapath controls and
//           status/perf counters out)
// Parameters: INST_W (opcode = inst[INST_W-1 -: 4]), WAIT_MAX (0 = no timeout),
//   CNT_W (perf counter width).
// Optional feature: define MC_CTRL_PERF_EN to build the cycle/instret
//   counters; otherwise both counter outputs are tied to 0.
// ---------------------------------------------------------------------------
module multicycle_ctrl_p #(
  parameter int INST_W   = 16,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic              clock,
  input  logic              rst,
  multicycle_ctrl_p_if.slave bus
);

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_JUMP   = 4'd2,
    S_STORE  = 4'd3,
    S_LOAD1  = 4'd4,
    S_LOAD2  = 4'd5,
    S_BRANCH = 4'd6,
    S_DTYPE  = 4'd7,
    S_D1     = 4'd8,
    S_CTYPE  = 4'd9,
    S_CTYPE1 = 4'd10,
    S_FAULT  = 4'd15
  } state_t;

  localparam int WAIT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [WAIT_W-1:0] wait_cnt_nxt_s;
  logic              mem_state_s;
  logic              timeout_s;
  logic [3:0]        opcode_s;

  assign opcode_s = bus.inst[INST_W-1 -: 4];

  // Memory-access states are the only ones that wait on mem_ready
  always_comb begin
    mem_state_s = (state_r == S_IF) || (state_r == S_LOAD1) || (state_r == S_STORE);
  end

  // Timeout: budget exhausted and the access still not done (a late mem_ready wins)
  always_comb begin
    if (WAIT_MAX > 0) begin
      timeout_s = mem_state_s && (wait_cnt_r == WAIT_W'(WAIT_MAX)) && !bus.mem_ready;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Wait counter: counts stalled cycles within one access, zero everywhere else
  always_comb begin
    wait_cnt_nxt_s = {WAIT_W{1'b0}};
    if (mem_state_s && !bus.mem_ready && !timeout_s && (WAIT_MAX > 0)) begin
      wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
    end else begin
      wait_cnt_nxt_s = {WAIT_W{1'b0}};
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IF: begin
        if (timeout_s) begin
          state_nxt_s = S_FAULT;
        end else if (bus.mem_ready) begin
          state_nxt_s = S_ID;
        end else begin
          state_nxt_s = S_IF;
        end
      end
      S_ID: begin
        case (opcode_s[3:2])
          2'b00: begin
            case (opcode_s[1:0])
              2'b00:   state_nxt_s = S_LOAD1;
              2'b01:   state_nxt_s = S_STORE;
              2'b10:   state_nxt_s = S_JUMP;
              default: state_nxt_s = S_FAULT;  // 0011 is illegal
            endcase
          end
          2'b01: state_nxt_s = S_BRANCH;
          2'b10: begin
            // inst[7] marks a C-class no-op that retires straight from decode
            if (bus.inst[7]) begin
              state_nxt_s = S_IF;
            end else begin
              state_nxt_s = S_CTYPE;
            end
          end
          default: state_nxt_s = S_DTYPE;
        endcase
      end
      S_LOAD1: begin
        if (timeout_s) begin
          state_nxt_s = S_FAULT;
        end else if (bus.mem_ready) begin
          state_nxt_s = S_LOAD2;
        end else begin
          state_nxt_s = S_LOAD1;
        end
      end
      S_STORE: begin
        if (timeout_s) begin
          state_nxt_s = S_FAULT;
        end else if (bus.mem_ready) begin
          state_nxt_s = S_IF;
        end else begin
          state_nxt_s = S_STORE;
        end
      end
      S_LOAD2:  state_nxt_s = S_IF;
      S_JUMP:   state_nxt_s = S_IF;
      S_BRANCH: state_nxt_s = S_IF;
      S_CTYPE:  state_nxt_s = S_CTYPE1;
      S_CTYPE1: state_nxt_s = S_IF;
      S_DTYPE:  state_nxt_s = S_D1;
      S_D1:     state_nxt_s = S_IF;
      S_FAULT:  state_nxt_s = S_FAULT;
      default:  state_nxt_s = S_FAULT;  // unused encodings are treated as corruption
    endcase
  end

  // State and wait-counter registers
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_r    <= S_IF;
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end

  // Control outputs decoded from the current state; all forced low during reset
  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.zero_in       = 1'b0;
    bus.iord          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.reg_dst1      = 1'b0;
    bus.reg_write1    = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst2      = 1'b0;
    bus.reg_write2    = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.pc_src        = 2'b00;
    bus.alu_op        = 3'b000;
    bus.fault         = 1'b0;
    bus.state_dbg     = 4'h0;
    if (rst) begin
      bus.fault = 1'b0;  // everything stays at its cleared default
    end else begin
      bus.state_dbg = state_r;
      case (state_r)
        S_IF: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'b10;
          bus.alu_op    = 3'b100;
          // PC/IR update only in the cycle the fetch completes
          bus.ir_write  = bus.mem_ready;
          bus.pc_write  = bus.mem_ready;
        end
        S_LOAD1: begin
          bus.iord     = 1'b1;
          bus.mem_read = 1'b1;
        end
        S_LOAD2: begin
          bus.reg_write1 = 1'b1;
          bus.mem_to_reg = 1'b1;
        end
        S_STORE: begin
          bus.iord      = 1'b1;
          bus.mem_write = 1'b1;
        end
        S_JUMP: begin
          bus.pc_src   = 2'b10;
          bus.pc_write = 1'b1;
        end
        S_BRANCH: begin
          bus.alu_src_a     = 1'b1;
          bus.alu_op        = 3'b101;
          bus.pc_src        = 2'b01;
          bus.pc_write_cond = 1'b1;
          bus.zero_in       = bus.zero_out;
        end
        S_CTYPE: begin
          bus.alu_src_a = 1'b1;
        end
        S_CTYPE1: begin
          bus.reg_write2 = 1'b1;
          bus.reg_dst2   = bus.inst[0];
        end
        S_DTYPE: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b01;
          bus.alu_op    = opcode_s[2:0];
        end
        S_D1: begin
          bus.reg_write1 = 1'b1;
        end
        S_FAULT: begin
          bus.fault = 1'b1;
        end
        default: begin
          bus.fault = 1'b0;
        end
      endcase
    end
  end

`ifdef MC_CTRL_PERF_EN
  logic [CNT_W-1:0] cycle_cnt_r;
  logic [CNT_W-1:0] instret_cnt_r;

  // Perf counters: frozen in FAULT; an instruction retires on each return to IF
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cycle_cnt_r   <= {CNT_W{1'b0}};
      instret_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r != S_FAULT) begin
      cycle_cnt_r <= cycle_cnt_r + CNT_W'(1);
      if ((state_nxt_s == S_IF) && (state_r != S_IF)) begin
        instret_cnt_r <= instret_cnt_r + CNT_W'(1);
      end
    end
  end

  assign bus.cycle_cnt   = cycle_cnt_r;
  assign bus.instret_cnt = instret_cnt_r;
`else
  assign bus.cycle_cnt   = {CNT_W{1'b0}};
  assign bus.instret_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_multicycle_ctrl_p.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl_p
// Directed scenarios followed by random instruction streams. Each instruction
// is expanded into the list of states its class visits, with random memory
// wait lengths; every cycle the full control vector and the perf counters
// are compared against values computed from the state/output table.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl_p;

  localparam int INST_W   = 16;
  localparam int WAIT_MAX = 4;
  localparam int CNT_W    = 4;

  localparam logic [3:0] ST_IF = 4'd0, ST_ID = 4'd1, ST_JUMP = 4'd2, ST_STORE = 4'd3,
                         ST_LOAD1 = 4'd4, ST_LOAD2 = 4'd5, ST_BRANCH = 4'd6,
                         ST_DTYPE = 4'd7, ST_D1 = 4'd8, ST_CTYPE = 4'd9,
                         ST_CTYPE1 = 4'd10, ST_FAULT = 4'd15;

`ifdef MC_CTRL_PERF_EN
  localparam logic [31:0] CNT_MASK = (32'd1 << CNT_W) - 32'd1;
`else
  localparam logic [31:0] CNT_MASK = 32'd0;
`endif

  logic clock = 1'b0;
  logic rst   = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   instret = 0;

  multicycle_ctrl_p_if #(.INST_W(INST_W), .CNT_W(CNT_W)) bus_if ();

  multicycle_ctrl_p #(.INST_W(INST_W), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;

  logic [24:0] obs;
  assign obs = {bus_if.pc_write, bus_if.pc_write_cond, bus_if.zero_in, bus_if.iord,
                bus_if.mem_read, bus_if.mem_write, bus_if.ir_write, bus_if.reg_dst1,
                bus_if.reg_write1, bus_if.mem_to_reg, bus_if.reg_dst2, bus_if.reg_write2,
                bus_if.alu_src_a, bus_if.alu_src_b, bus_if.pc_src, bus_if.alu_op,
                bus_if.fault, bus_if.state_dbg};

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected control vector for a state, straight from the output table
  function automatic logic [24:0] exp_vec(input logic [3:0] st, input logic [15:0] in,
                                          input logic z, input logic rdy);
    logic pcw, pcwc, zin, iord, mrd, mwr, irw, rd1, rw1, m2r, rd2, rw2, asa, flt;
    logic [1:0] asb, pcs;
    logic [2:0] aop;
    {pcw, pcwc, zin, iord, mrd, mwr, irw, rd1, rw1, m2r, rd2, rw2, asa, flt} = 14'd0;
    asb = 2'b00; pcs = 2'b00; aop = 3'b000;
    case (st)
      ST_IF:     begin mrd = 1'b1; asb = 2'b10; aop = 3'b100; irw = rdy; pcw = rdy; end
      ST_LOAD1:  begin iord = 1'b1; mrd = 1'b1; end
      ST_LOAD2:  begin rw1 = 1'b1; m2r = 1'b1; end
      ST_STORE:  begin iord = 1'b1; mwr = 1'b1; end
      ST_JUMP:   begin pcs = 2'b10; pcw = 1'b1; end
      ST_BRANCH: begin asa = 1'b1; aop = 3'b101; pcs = 2'b01; pcwc = 1'b1; zin = z; end
      ST_CTYPE:  begin asa = 1'b1; end
      ST_CTYPE1: begin rw2 = 1'b1; rd2 = in[0]; end
      ST_DTYPE:  begin asa = 1'b1; asb = 2'b01; aop = in[14:12]; end
      ST_D1:     begin rw1 = 1'b1; end
      ST_FAULT:  begin flt = 1'b1; end
      default:   begin flt = 1'b0; end
    endcase
    return {pcw, pcwc, zin, iord, mrd, mwr, irw, rd1, rw1, m2r, rd2, rw2, asa, asb, pcs, aop, flt, st};
  endfunction

  task automatic check_vec(input string tag, input logic [24:0] o, input logic [24:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  // One cycle in state st; called at a negedge, returns at the next negedge
  task automatic do_state(input logic [3:0] st, input logic rdy, input logic z);
    bus_if.mem_ready = rdy;
    bus_if.zero_out  = z;
    #1;
    check_vec($sformatf("state%0d", st), obs, exp_vec(st, bus_if.inst, z, rdy));
    check_val("cycle_cnt", 32'(bus_if.cycle_cnt), 32'(cyc) & CNT_MASK);
    check_val("instret_cnt", 32'(bus_if.instret_cnt), 32'(instret) & CNT_MASK);
    if (st != ST_FAULT) cyc++;
    @(negedge clock);
  endtask

  // A memory access stalled for w cycles; times out if w exceeds the budget
  task automatic mem_phase(input logic [3:0] st, input int w, output bit faulted);
    faulted = 1'b0;
    for (int k = 0; k <= w; k++) begin
      if (k == w) begin
        do_state(st, 1'b1, rbit());
      end else if (k == WAIT_MAX) begin
        do_state(st, 1'b0, rbit());
        faulted = 1'b1;
        break;
      end else begin
        do_state(st, 1'b0, rbit());
      end
    end
  endtask

  task automatic reset_seq();
    bus_if.mem_ready = 1'b1;
    bus_if.zero_out  = 1'b1;
    rst = 1'b1;
    #1;
    check_vec("reset_outputs", obs, 25'd0);
    check_val("reset_cycle_cnt", 32'(bus_if.cycle_cnt), 32'd0);
    @(negedge clock);
    @(negedge clock);
    rst = 1'b0;
    cyc = 0;
    instret = 0;
  endtask

  task automatic fault_tail();
    for (int i = 0; i < 3; i++) do_state(ST_FAULT, rbit(), rbit());
    reset_seq();
  endtask

  task automatic run_inst(input logic [15:0] in, input int wf, input int wm);
    bit f;
    bus_if.inst = in;
    mem_phase(ST_IF, wf, f);
    if (f) begin
      fault_tail();
      return;
    end
    do_state(ST_ID, rbit(), rbit());
    case (in[15:14])
      2'b00: begin
        case (in[13:12])
          2'b00: begin
            mem_phase(ST_LOAD1, wm, f);
            if (!f) do_state(ST_LOAD2, rbit(), rbit());
          end
          2'b01:   mem_phase(ST_STORE, wm, f);
          2'b10:   do_state(ST_JUMP, rbit(), rbit());
          default: f = 1'b1;
        endcase
      end
      2'b01: do_state(ST_BRANCH, rbit(), rbit());
      2'b10: begin
        if (!in[7]) begin
          do_state(ST_CTYPE, rbit(), rbit());
          do_state(ST_CTYPE1, rbit(), rbit());
        end
      end
      default: begin
        do_state(ST_DTYPE, rbit(), rbit());
        do_state(ST_D1, rbit(), rbit());
      end
    endcase
    if (f) fault_tail();
    else instret++;
  endtask

  initial begin
    bit f;
    logic [15:0] rin;
    int wf, wm;
    bus_if.inst = 16'h0000;
    bus_if.zero_out = 1'b0;
    bus_if.mem_ready = 1'b0;
    #1;
    reset_seq();

    // Reset in the middle of a stalled LOAD1, then resume from IF
    bus_if.inst = 16'h0000;
    mem_phase(ST_IF, 0, f);
    do_state(ST_ID, 1'b1, 1'b0);
    do_state(ST_LOAD1, 1'b0, 1'b0);
    do_state(ST_LOAD1, 1'b0, 1'b0);
    reset_seq();

    // Zero-wait load, stalled fetch, store timeout, ready on the timeout cycle
    run_inst(16'h0000, 0, 0);
    run_inst(16'hC5A3, 3, 0);
    run_inst(16'h1000, 0, 5);
    run_inst(16'h1000, 0, WAIT_MAX);
    run_inst(16'h0000, WAIT_MAX, WAIT_MAX);

    // Illegal opcode, then branch taken with zero_out=1
    run_inst(16'h3000, 0, 0);
    bus_if.inst = 16'h4000;
    mem_phase(ST_IF, 0, f);
    do_state(ST_ID, 1'b0, 1'b0);
    do_state(ST_BRANCH, 1'b0, 1'b1);
    instret++;

    // C-class both flavours, then fetch timeout
    run_inst(16'h8081, 1, 0);
    run_inst(16'h8001, 0, 0);
    run_inst(16'h8000, 0, 0);
    run_inst(16'hE000, 7, 0);

    // 20 jumps from reset: counters wrap at 2^CNT_W
    reset_seq();
    for (int i = 0; i < 20; i++) run_inst(16'h2000, 0, 0);
    check_val("perf_cycle_20jumps", 32'(bus_if.cycle_cnt), 32'd12 & CNT_MASK);
    check_val("perf_instret_20jumps", 32'(bus_if.instret_cnt), 32'd4 & CNT_MASK);

    // Random instruction stream
    for (int n = 0; n < 200; n++) begin
      rin = 16'($urandom());
      wf = ($urandom_range(0, 11) == 0) ? WAIT_MAX + 2 : int'($urandom_range(0, WAIT_MAX));
      wm = ($urandom_range(0, 11) == 0) ? WAIT_MAX + 1 : int'($urandom_range(0, WAIT_MAX));
      run_inst(rin, wf, wm);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
